// File: rtl/seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants, state encoding and helpers for the
//                symbol sequence feeder (seq_feeder / sym_counter).
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

   // Width of one emitted symbol; matches the downstream FSM input `a`.
   localparam int SYM_W = 2;

   // Default stored pattern width (must be a multiple of SYM_W).
   localparam int PAT_W_DEFAULT = 18;

   // Width of the length and index fields.
   localparam int LEN_W = 5;

   // Feeder state encoding.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Saturate a requested symbol count to the number of symbols the pattern holds.
   function automatic logic [LEN_W-1:0] clamp_len(
      input logic [LEN_W-1:0] len,
      input logic [LEN_W-1:0] max_sym
   );
      return (len > max_sym) ? max_sym : len;
   endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/sym_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sym_counter
//  Description : Symbol index counter. Increments on every accepted symbol,
//                wraps to zero after the last symbol of the stored length and
//                flags the last symbol with a full-width compare.
//  Revision    : 1.0  initial release
// ============================================================================
module sym_counter
   import seq_pkg::*;
#(
   parameter int MAX_SYM = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [LEN_W-1:0] idx_o,
   output logic             last_o
);

   // Highest index the pattern can ever hold; acts as a hard ceiling.
   localparam logic [LEN_W-1:0] TOP_IDX = LEN_W'(MAX_SYM - 1);

   logic [LEN_W-1:0] idx_q;
   logic [LEN_W-1:0] idx_d;
   logic             at_top;

   // Last-symbol detect at the full index width (length is never 0 while counting).
   assign last_o = (idx_q == (len_i - LEN_W'(1)));
   assign at_top = (idx_q == TOP_IDX);
   assign idx_o  = idx_q;

   // Next index: clear dominates, otherwise step on each accepted symbol.
   always_comb begin
      idx_d = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (advance_i) begin
         if (last_o || at_top) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + LEN_W'(1);
         end
      end
   end

   // Index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule : sym_counter
`default_nettype wire

// File: rtl/seq_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_feeder
//  Description : Stores a symbol pattern and length, then streams the symbols
//                LSB-first onto `a` with a valid/ready handshake. Supports
//                looping, abort, and a one-cycle completion pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_feeder
   import seq_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [4:0]       len_in,
   input  logic             start,
   input  logic             loop,
   input  logic             abort,
   input  logic             a_ready,
   output logic [SYM_W-1:0] a,
   output logic             a_valid,
   output logic             busy,
   output logic             done,
   output logic [4:0]       sym_idx
);

   // Number of symbols the pattern register holds.
   localparam int               MAX_SYM   = PAT_W / SYM_W;
   localparam logic [LEN_W-1:0] MAX_SYM_L = LEN_W'(MAX_SYM);

   state_e           state_q;
   state_e           state_d;
   logic [PAT_W-1:0] pattern_q;
   logic [PAT_W-1:0] pattern_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_d;
   // Completion pulse for a zero-length start, raised while staying in IDLE.
   logic             zdone_q;
   logic             zdone_d;

   logic             in_run;
   logic             xfer;
   logic [LEN_W-1:0] len_in_sat;
   logic [LEN_W-1:0] start_len;
   logic             cnt_clear;
   logic             cnt_advance;
   logic [LEN_W-1:0] cnt_idx;
   logic             cnt_last;
   logic [SYM_W-1:0] sym_sel;

   assign in_run     = (state_q == RUN);
   assign xfer       = in_run && a_ready;
   assign len_in_sat = clamp_len(len_in, MAX_SYM_L);
   // A load in the same cycle as start takes effect for that start.
   assign start_len  = load ? len_in_sat : len_q;

   // The counter is held at zero outside RUN and on abort, so every run starts at symbol 0.
   assign cnt_clear   = !in_run || abort;
   assign cnt_advance = xfer && !abort;

   sym_counter #(
      .MAX_SYM (MAX_SYM)
   ) u_sym_counter (
      .clk       (clk),
      .rst_n     (reset),
      .clear_i   (cnt_clear),
      .advance_i (cnt_advance),
      .len_i     (len_q),
      .idx_o     (cnt_idx),
      .last_o    (cnt_last)
   );

   // Next-state logic: abort wins over everything, load/start only act in IDLE.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      zdone_d   = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  pattern_d = pattern_in;
                  len_d     = len_in_sat;
               end
               if (start) begin
                  if (start_len != '0) begin
                     state_d = RUN;
                  end else begin
                     zdone_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (xfer && cnt_last && !loop) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, pattern and length registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         zdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         zdone_q   <= zdone_d;
      end
   end

   // Symbol select: a plain mux over the registered pattern, indexed by the counter.
   always_comb begin
      sym_sel = '0;
      for (int i = 0; i < MAX_SYM; i++) begin
         if (cnt_idx == LEN_W'(i)) begin
            sym_sel = pattern_q[SYM_W*i +: SYM_W];
         end
      end
   end

   // Outputs are gated by RUN so they drop as soon as the state register resets.
   always_comb begin
      a       = in_run ? sym_sel : '0;
      a_valid = in_run;
      busy    = in_run;
      sym_idx = in_run ? cnt_idx : '0;
      done    = (state_q == DONE) || zdone_q;
   end

endmodule : seq_feeder
`default_nettype wire

// File: tb/tb_seq_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_feeder
//  Description : Self-checking bench for seq_feeder. Expected symbols are
//                queued when a run is launched and popped on every handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_feeder;

   localparam int PAT_W = 18;
   localparam int MAXC  = 40;
   localparam logic [PAT_W-1:0] PAT_A = 18'h1697B;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic             start = 1'b0;
   logic             loop = 1'b0;
   logic             abort = 1'b0;
   logic             a_ready = 1'b0;
   logic [PAT_W-1:0] pattern_in = '0;
   logic [4:0]       len_in = '0;
   logic [1:0]       a;
   logic             a_valid;
   logic             busy;
   logic             done;
   logic [4:0]       sym_idx;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [4:0] idx;
      logic [1:0] sym;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   // Per-cycle history of the last run (index 1 = first cycle after start edge).
   logic [1:0] a_h    [MAXC+1];
   logic [4:0] idx_h  [MAXC+1];
   logic       v_h    [MAXC+1];
   logic       d_h    [MAXC+1];
   logic       b_h    [MAXC+1];

   always #5 clk = ~clk;

   seq_feeder #(
      .PAT_W (PAT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .pattern_in (pattern_in),
      .len_in     (len_in),
      .start      (start),
      .loop       (loop),
      .abort      (abort),
      .a_ready    (a_ready),
      .a          (a),
      .a_valid    (a_valid),
      .busy       (busy),
      .done       (done),
      .sym_idx    (sym_idx)
   );

   // Reference model: symbol i of a pattern, LSB symbol first.
   function automatic logic [1:0] mdl_sym(input logic [PAT_W-1:0] p, input int i);
      logic [PAT_W-1:0] t;
      t = p >> (2 * i);
      return t[1:0];
   endfunction

   function automatic int mdl_len(input int l);
      return (l > 9) ? 9 : l;
   endfunction

   function automatic int first_done(input int n);
      for (int c = 1; c <= n; c++) if (d_h[c] === 1'b1) return c;
      return 0;
   endfunction

   function automatic int count_done(input int lo, input int hi);
      int k;
      k = 0;
      for (int c = lo; c <= hi; c++) if (d_h[c] === 1'b1) k++;
      return k;
   endfunction

   function automatic int count_valid(input int n);
      int k;
      k = 0;
      for (int c = 1; c <= n; c++) if (v_h[c] !== 1'b0 || b_h[c] !== 1'b0) k++;
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the expected handshakes of a run: n transfers over a pattern of length len.
   task automatic push_run(input logic [PAT_W-1:0] p, input int len, input int n);
      for (int k = 0; k < n; k++) begin
         sb_e.idx = 5'(k % len);
         sb_e.sym = mdl_sym(p, k % len);
         sb_q.push_back(sb_e);
      end
   endtask

   // Load a pattern/length, then pulse start; returns just after the start edge.
   task automatic launch(input logic [PAT_W-1:0] p, input logic [4:0] l);
      pattern_in = p;
      len_in     = l;
      load       = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Drive a_ready/loop/abort per cycle, record outputs and score every handshake.
   task automatic run_cycles(input int n, input logic [MAXC:0] stall,
                             input int loop_until, input int abort_at);
      for (int c = 1; c <= n; c++) begin
         a_ready = !stall[c];
         loop    = (c <= loop_until);
         abort   = (c == abort_at);
         @(negedge clk);
         a_h[c]   = a;
         idx_h[c] = sym_idx;
         v_h[c]   = a_valid;
         d_h[c]   = done;
         b_h[c]   = busy;
         if (a_valid && a_ready && !abort) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL xfer_unexpected: cycle %0d got idx=%0d a=%0d, required no transfer",
                        c, sym_idx, a);
            end else begin
               sb_e = sb_q.pop_front();
               if ({sym_idx, a} !== {sb_e.idx, sb_e.sym}) begin
                  n_err++;
                  $display("FAIL xfer_data: cycle %0d got idx=%0d a=%0d, required idx=%0d a=%0d",
                           c, sym_idx, a, sb_e.idx, sb_e.sym);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      a_ready = 1'b0;
      loop    = 1'b0;
      abort   = 1'b0;
   endtask

   task automatic check_sb_empty(input string name);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_pending: got %0d expected transfers left, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if ({a, a_valid, busy, done, sym_idx} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got a=%0d v=%0d busy=%0d done=%0d idx=%0d, required all 0",
                  a, a_valid, busy, done, sym_idx);
      end
      tick();
      reset = 1'b1;
      tick();
      // Stored length is 0 out of reset: start must only pulse done.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_cycles(4, '0, 0, 0);
      n_cmp++;
      if (first_done(4) !== 1 || count_done(1, 4) !== 1) begin
         n_err++;
         $display("FAIL reset_len0_done: got first=%0d count=%0d, required first=1 count=1",
                  first_done(4), count_done(1, 4));
      end
   endtask

   task automatic test_basic();
      logic [1:0] ref_seq [9];
      ref_seq = '{2'd3, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
      launch(PAT_A, 5'd9);
      push_run(PAT_A, 9, 9);
      // A load while running must not disturb the stored pattern.
      load       = 1'b1;
      pattern_in = ~PAT_A;
      run_cycles(14, '0, 0, 0);
      load = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         n_cmp++;
         if (a_h[c] !== ref_seq[c-1]) begin
            n_err++;
            $display("FAIL basic_seq: cycle %0d got a=%0d, required %0d", c, a_h[c], ref_seq[c-1]);
         end
      end
      n_cmp++;
      if (first_done(14) !== 10 || count_done(1, 14) !== 1) begin
         n_err++;
         $display("FAIL basic_done: got first=%0d count=%0d, required first=10 count=1",
                  first_done(14), count_done(1, 14));
      end
      n_cmp++;
      if (b_h[1] !== 1'b1 || b_h[10] !== 1'b0 || v_h[10] !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy: got busy1=%0d busy10=%0d valid10=%0d, required 1 0 0",
                  b_h[1], b_h[10], v_h[10]);
      end
      check_sb_empty("basic");
   endtask

   task automatic test_stall();
      logic [MAXC:0] m;
      m    = '0;
      m[2] = 1'b1;
      m[3] = 1'b1;
      m[4] = 1'b1;
      launch(PAT_A, 5'd9);
      push_run(PAT_A, 9, 9);
      run_cycles(16, m, 0, 0);
      for (int c = 2; c <= 4; c++) begin
         n_cmp++;
         if (a_h[c] !== 2'd2 || idx_h[c] !== 5'd1 || v_h[c] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold: cycle %0d got a=%0d idx=%0d v=%0d, required a=2 idx=1 v=1",
                     c, a_h[c], idx_h[c], v_h[c]);
         end
      end
      n_cmp++;
      if (first_done(16) !== 13 || count_done(1, 16) !== 1) begin
         n_err++;
         $display("FAIL stall_done: got first=%0d count=%0d, required first=13 count=1",
                  first_done(16), count_done(1, 16));
      end
      check_sb_empty("stall");
   endtask

   task automatic test_loop();
      logic [1:0] ref_seq [7];
      ref_seq = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3};
      launch(PAT_A, 5'd3);
      push_run(PAT_A, 3, 9);
      run_cycles(14, '0, 7, 0);
      for (int c = 1; c <= 7; c++) begin
         n_cmp++;
         if (a_h[c] !== ref_seq[c-1]) begin
            n_err++;
            $display("FAIL loop_seq: cycle %0d got a=%0d, required %0d", c, a_h[c], ref_seq[c-1]);
         end
      end
      n_cmp++;
      if (count_done(1, 9) !== 0 || first_done(14) !== 10 || count_done(1, 14) !== 1) begin
         n_err++;
         $display("FAIL loop_done: got early=%0d first=%0d count=%0d, required 0 10 1",
                  count_done(1, 9), first_done(14), count_done(1, 14));
      end
      check_sb_empty("loop");
   endtask

   task automatic test_len_clamp();
      logic [PAT_W-1:0] p;
      p          = PAT_W'($urandom);
      pattern_in = p;
      len_in     = 5'd20;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      push_run(p, mdl_len(20), 9);
      run_cycles(14, '0, 0, 0);
      n_cmp++;
      if (first_done(14) !== 10 || count_done(1, 14) !== 1 || idx_h[9] !== 5'd8) begin
         n_err++;
         $display("FAIL clamp_done: got first=%0d count=%0d idx9=%0d, required 10 1 8",
                  first_done(14), count_done(1, 14), idx_h[9]);
      end
      check_sb_empty("clamp");
   endtask

   task automatic test_len_zero();
      pattern_in = PAT_A;
      len_in     = 5'd0;
      load       = 1'b1;
      start      = 1'b1;
      tick();
      load  = 1'b0;
      start = 1'b0;
      run_cycles(5, '0, 0, 0);
      n_cmp++;
      if (first_done(5) !== 1 || count_done(1, 5) !== 1) begin
         n_err++;
         $display("FAIL zero_done: got first=%0d count=%0d, required first=1 count=1",
                  first_done(5), count_done(1, 5));
      end
      n_cmp++;
      if (count_valid(5) !== 0) begin
         n_err++;
         $display("FAIL zero_valid: got %0d active cycles, required 0", count_valid(5));
      end
   endtask

   task automatic test_abort();
      launch(PAT_A, 5'd9);
      push_run(PAT_A, 9, 4);
      run_cycles(12, '0, 0, 5);
      n_cmp++;
      if (idx_h[5] !== 5'd4 || v_h[5] !== 1'b1) begin
         n_err++;
         $display("FAIL abort_pre: got idx=%0d v=%0d, required idx=4 v=1", idx_h[5], v_h[5]);
      end
      n_cmp++;
      if (v_h[6] !== 1'b0 || b_h[6] !== 1'b0 || idx_h[6] !== 5'd0 || a_h[6] !== 2'd0) begin
         n_err++;
         $display("FAIL abort_idle: got v=%0d busy=%0d idx=%0d a=%0d, required all 0",
                  v_h[6], b_h[6], idx_h[6], a_h[6]);
      end
      n_cmp++;
      if (count_done(1, 12) !== 0) begin
         n_err++;
         $display("FAIL abort_nodone: got %0d done cycles, required 0", count_done(1, 12));
      end
      check_sb_empty("abort");
   endtask

   task automatic test_reset_mid();
      launch(PAT_A, 5'd9);
      push_run(PAT_A, 9, 5);
      run_cycles(5, '0, 0, 0);
      #2;
      n_cmp++;
      if (sym_idx !== 5'd5 || a !== mdl_sym(PAT_A, 5) || a_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_pre: got idx=%0d a=%0d v=%0d, required idx=5 a=%0d v=1",
                  sym_idx, a, a_valid, mdl_sym(PAT_A, 5));
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({a, a_valid, busy, done, sym_idx} !== 10'd0) begin
         n_err++;
         $display("FAIL rstmid_async: got a=%0d v=%0d busy=%0d done=%0d idx=%0d, required all 0",
                  a, a_valid, busy, done, sym_idx);
      end
      check_sb_empty("rstmid");
      tick();
      reset = 1'b1;
      run_cycles(4, '0, 0, 0);
      n_cmp++;
      if (count_done(1, 4) !== 0 || count_valid(4) !== 0) begin
         n_err++;
         $display("FAIL rstmid_quiet: got done=%0d active=%0d, required 0 0",
                  count_done(1, 4), count_valid(4));
      end
      launch(PAT_A, 5'd9);
      push_run(PAT_A, 9, 9);
      run_cycles(14, '0, 0, 0);
      n_cmp++;
      if (first_done(14) !== 10 || count_done(1, 14) !== 1) begin
         n_err++;
         $display("FAIL rstmid_replay: got first=%0d count=%0d, required first=10 count=1",
                  first_done(14), count_done(1, 14));
      end
      check_sb_empty("replay");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_loop();
      test_len_clamp();
      test_len_zero();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_feeder
`default_nettype wire
